// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router definitions for the transmit link arbiter
//
// Purpose: frame width, grant source encodings and the arbiter state type.
// Ports:   none (package).
package router_pkg;

    localparam int FRAME_W = 55;

    localparam logic SRC_FWD = 1'b0;
    localparam logic SRC_LOC = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/tx_link_arbiter.sv
// rtl/tx_link_arbiter.sv - two-source arbiter feeding the serial transmit link
//
// Purpose: holds one frame at a time, taken from the forward (receive) path or
//          the local node, and presents it to the transmitter until accepted.
//          Forward traffic has priority; local traffic waits for at most
//          MAX_FWD consecutive forward grants.
// Ports:
//   Clk_R, Rst                   clock and synchronous active-high reset
//   Fwd_Data/Fwd_Valid/Fwd_Ready forward frame source handshake
//   Loc_Data/Loc_Valid/Loc_Ready local frame source handshake
//   TX_Data/TX_Data_Valid/TX_Data_Ready  transmitter parallel port
//   Grant_Src                    source of held frame (0 forward, 1 local)
//   Fwd_Count/Loc_Count          wrapping counts of frames accepted by the transmitter
module tx_link_arbiter #(
    parameter int FRAME_W = router_pkg::FRAME_W,
    parameter int MAX_FWD = 4,
    parameter int CNT_W   = 16
) (
    input  logic               Clk_R,
    input  logic               Rst,
    input  logic [FRAME_W-1:0] Fwd_Data,
    input  logic               Fwd_Valid,
    output logic               Fwd_Ready,
    input  logic [FRAME_W-1:0] Loc_Data,
    input  logic               Loc_Valid,
    output logic               Loc_Ready,
    output logic [FRAME_W-1:0] TX_Data,
    output logic               TX_Data_Valid,
    input  logic               TX_Data_Ready,
    output logic               Grant_Src,
    output logic [CNT_W-1:0]   Fwd_Count,
    output logic [CNT_W-1:0]   Loc_Count
);
    import router_pkg::*;

    localparam logic [3:0] MAX_FWD_L = 4'(MAX_FWD);

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               src_q, src_d;
    logic [3:0]         streak_q, streak_d;
    logic [CNT_W-1:0]   fwd_cnt_q, fwd_cnt_d;
    logic [CNT_W-1:0]   loc_cnt_q, loc_cnt_d;

    logic fwd_win;
    logic loc_win;
    logic fwd_take;
    logic loc_take;

    // Forward wins every contest except when local has already watched
    // MAX_FWD forward grants go by.
    assign fwd_win = Fwd_Valid && !(Loc_Valid && (streak_q == MAX_FWD_L));
    assign loc_win = Loc_Valid && !fwd_win;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        src_d     = src_q;
        streak_d  = streak_q;
        fwd_cnt_d = fwd_cnt_q;
        loc_cnt_d = loc_cnt_q;
        fwd_take  = 1'b0;
        loc_take  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fwd_win) begin
                    fwd_take = 1'b1;
                    frame_d  = Fwd_Data;
                    src_d    = SRC_FWD;
                    state_d  = SEND;
                    // Streak only grows while local is actually waiting.
                    if (!Loc_Valid) begin
                        streak_d = 4'd0;
                    end else if (streak_q < MAX_FWD_L) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (loc_win) begin
                    loc_take = 1'b1;
                    frame_d  = Loc_Data;
                    src_d    = SRC_LOC;
                    state_d  = SEND;
                    streak_d = 4'd0;
                end
            end
            SEND: begin
                // No bypass: a new request is only looked at in the next IDLE cycle.
                if (TX_Data_Ready) begin
                    if (src_q == SRC_LOC) begin
                        loc_cnt_d = loc_cnt_q + 1'b1;
                    end else begin
                        fwd_cnt_d = fwd_cnt_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            src_q     <= SRC_FWD;
            streak_q  <= 4'd0;
            fwd_cnt_q <= '0;
            loc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            src_q     <= src_d;
            streak_q  <= streak_d;
            fwd_cnt_q <= fwd_cnt_d;
            loc_cnt_q <= loc_cnt_d;
        end
    end

    // Readys are suppressed during reset so no source believes a frame was taken.
    assign Fwd_Ready     = fwd_take && !Rst;
    assign Loc_Ready     = loc_take && !Rst;
    assign TX_Data       = frame_q;
    assign TX_Data_Valid = (state_q == SEND);
    assign Grant_Src     = src_q;
    assign Fwd_Count     = fwd_cnt_q;
    assign Loc_Count     = loc_cnt_q;

endmodule

// File: tb/tb_tx_link_arbiter.sv
// tb/tb_tx_link_arbiter.sv - self-checking bench for tx_link_arbiter
module tb_tx_link_arbiter;

    localparam int FW  = 55;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] fwd_data, loc_data;
    logic          fwd_valid, loc_valid, tx_ready;
    logic          fwd_ready, loc_ready, tx_valid, grant_src;
    logic [FW-1:0] tx_data;
    logic [15:0]   fwd_count, loc_count;

    logic          s_fwd_ready, s_loc_ready, s_tx_valid, s_grant_src;
    logic [FW-1:0] s_tx_data;
    logic [3:0]    s_fwd_count, s_loc_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tx_link_arbiter #(.FRAME_W(FW), .MAX_FWD(MAX), .CNT_W(16)) dut (
        .Clk_R(clk), .Rst(rst),
        .Fwd_Data(fwd_data), .Fwd_Valid(fwd_valid), .Fwd_Ready(fwd_ready),
        .Loc_Data(loc_data), .Loc_Valid(loc_valid), .Loc_Ready(loc_ready),
        .TX_Data(tx_data), .TX_Data_Valid(tx_valid), .TX_Data_Ready(tx_ready),
        .Grant_Src(grant_src), .Fwd_Count(fwd_count), .Loc_Count(loc_count)
    );

    // Narrow-counter copy sharing the same stimulus, used for wrap checks.
    tx_link_arbiter #(.FRAME_W(FW), .MAX_FWD(MAX), .CNT_W(4)) dut_w (
        .Clk_R(clk), .Rst(rst),
        .Fwd_Data(fwd_data), .Fwd_Valid(fwd_valid), .Fwd_Ready(s_fwd_ready),
        .Loc_Data(loc_data), .Loc_Valid(loc_valid), .Loc_Ready(s_loc_ready),
        .TX_Data(s_tx_data), .TX_Data_Valid(s_tx_valid), .TX_Data_Ready(tx_ready),
        .Grant_Src(s_grant_src), .Fwd_Count(s_fwd_count), .Loc_Count(s_loc_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        fwd_valid = 1'b0;
        loc_valid = 1'b0;
        tx_ready  = 1'b0;
        fwd_data  = '0;
        loc_data  = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    typedef struct {
        logic fv;
        logic lv;
        logic exp_fr;
        logic exp_lr;
        logic exp_valid;
        logic exp_src;
    } vec_t;

    vec_t vecs[14];

    // Reference model state (transaction level)
    logic          m_busy;
    logic [FW-1:0] m_frame;
    logic          m_src;
    int            m_streak, m_fc, m_lc;

    initial begin
        logic [FW-1:0] held;
        int            fp, lp;
        logic          e_fr, e_lr;

        vecs[0]  = '{1, 0, 1, 0, 1, 0};
        vecs[1]  = '{0, 1, 0, 1, 1, 1};
        vecs[2]  = '{0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 1, 1, 0, 1, 0};
        vecs[4]  = '{1, 1, 1, 0, 1, 0};
        vecs[5]  = '{1, 0, 1, 0, 1, 0};
        vecs[6]  = '{1, 1, 1, 0, 1, 0};
        vecs[7]  = '{1, 1, 1, 0, 1, 0};
        vecs[8]  = '{1, 1, 1, 0, 1, 0};
        vecs[9]  = '{1, 1, 1, 0, 1, 0};
        vecs[10] = '{1, 1, 0, 1, 1, 1};
        vecs[11] = '{1, 1, 1, 0, 1, 0};
        vecs[12] = '{0, 1, 0, 1, 1, 1};
        vecs[13] = '{1, 1, 1, 0, 1, 0};

        // Reset state, readys held low during reset even with a source valid
        rst = 1'b1; fwd_valid = 1'b1; loc_valid = 1'b1; tx_ready = 1'b0;
        fwd_data = 55'h11; loc_data = 55'h22;
        settle;
        chk("rst_fwd_ready", fwd_ready, 0);
        chk("rst_loc_ready", loc_ready, 0);
        tick; tick;
        rst = 1'b0; fwd_valid = 1'b0; loc_valid = 1'b0;
        settle;
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_grant", grant_src, 0);
        chk("reset_fwd_cnt", fwd_count, 0);
        chk("reset_loc_cnt", loc_count, 0);
        chk("idle_fwd_ready", fwd_ready, 0);
        chk("idle_loc_ready", loc_ready, 0);

        // Table: arbitration from IDLE with an always-ready transmitter
        tx_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            fwd_valid = vecs[i].fv; loc_valid = vecs[i].lv;
            fwd_data = 55'(i + 100); loc_data = 55'(i + 200);
            settle;
            chk($sformatf("vec%0d_fwd_ready", i), fwd_ready, vecs[i].exp_fr);
            chk($sformatf("vec%0d_loc_ready", i), loc_ready, vecs[i].exp_lr);
            tick;
            fwd_valid = 1'b0; loc_valid = 1'b0;
            settle;
            chk($sformatf("vec%0d_tx_valid", i), tx_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_src", i), grant_src, vecs[i].exp_src);
                chk($sformatf("vec%0d_data", i), tx_data,
                    vecs[i].exp_src ? 55'(i + 200) : 55'(i + 100));
                tick;
            end
        end

        // Lone local frame
        do_reset;
        tx_ready = 1'b1; loc_valid = 1'b1; loc_data = 55'h0_1234_5678;
        settle;
        chk("lone_loc_ready", loc_ready, 1);
        chk("lone_fwd_ready", fwd_ready, 0);
        tick;
        loc_valid = 1'b0;
        settle;
        chk("lone_tx_valid", tx_valid, 1);
        chk("lone_tx_data", tx_data, 55'h0_1234_5678);
        chk("lone_src", grant_src, 1);
        tick;
        settle;
        chk("lone_tx_valid_off", tx_valid, 0);
        chk("lone_loc_cnt", loc_count, 1);

        // Backpressure, with a second forward frame waiting behind
        do_reset;
        fwd_valid = 1'b1; fwd_data = 55'h7_ABCD_0001;
        settle;
        chk("bp_first_ready", fwd_ready, 1);
        tick;
        fwd_data = 55'h7_ABCD_0002;
        for (int i = 0; i < 10; i++) begin
            settle;
            chk("bp_tx_valid", tx_valid, 1);
            chk("bp_tx_data", tx_data, 55'h7_ABCD_0001);
            chk("bp_fwd_ready", fwd_ready, 0);
            chk("bp_fwd_cnt", fwd_count, 0);
            tick;
        end
        tx_ready = 1'b1;
        settle;
        chk("bp_accept_ready", fwd_ready, 0);
        chk("bp_cnt_before", fwd_count, 0);
        tick;
        tx_ready = 1'b0;
        settle;
        chk("bp_cnt_after", fwd_count, 1);
        chk("bp_idle_valid", tx_valid, 0);
        chk("bp_next_ready", fwd_ready, 1);
        tick;
        fwd_valid = 1'b0;
        settle;
        chk("bp_next_data", tx_data, 55'h7_ABCD_0002);

        // Starvation bound: F,F,F,F,L repeating
        do_reset;
        fwd_valid = 1'b1; loc_valid = 1'b1; tx_ready = 1'b1;
        fwd_data = 55'hF; loc_data = 55'hA;
        for (int k = 0; k < 20; k++) begin
            settle;
            chk($sformatf("starve%0d_fwd_ready", k), fwd_ready, (k % 5) != 4);
            chk($sformatf("starve%0d_loc_ready", k), loc_ready, (k % 5) == 4);
            tick;
            settle;
            chk($sformatf("starve%0d_src", k), grant_src, (k % 5) == 4);
            tick;
        end
        fwd_valid = 1'b0; loc_valid = 1'b0;
        settle;
        chk("starve_fwd_cnt", fwd_count, 16);
        chk("starve_loc_cnt", loc_count, 4);
        chk("starve_fwd_cnt_w", s_fwd_count, 0);
        chk("starve_loc_cnt_w", s_loc_count, 4);

        // Reset mid-SEND, source re-requests afterwards
        do_reset;
        fwd_valid = 1'b1; fwd_data = 55'h5_5555;
        tick;
        settle;
        chk("midrst_valid_before", tx_valid, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        settle;
        chk("midrst_valid_after", tx_valid, 0);
        chk("midrst_fwd_cnt", fwd_count, 0);
        chk("midrst_rerequest", fwd_ready, 1);
        tick;
        fwd_valid = 1'b0; tx_ready = 1'b1;
        settle;
        chk("midrst_resend_data", tx_data, 55'h5_5555);
        tick;
        settle;
        chk("midrst_cnt_final", fwd_count, 1);

        // Counter wrap on the narrow instance
        do_reset;
        tx_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            fwd_valid = 1'b1; fwd_data = 55'(k);
            tick;
            fwd_valid = 1'b0;
            tick;
        end
        settle;
        chk("wrap_fwd_cnt_w", s_fwd_count, 1);
        chk("wrap_fwd_cnt", fwd_count, 17);

        // Randomized traffic against the transaction-level model
        do_reset;
        m_busy = 0; m_frame = '0; m_src = 0; m_streak = 0; m_fc = 0; m_lc = 0;
        fp = 0; lp = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!fp && $urandom_range(0, 2) != 0) begin
                fp = 1; fwd_data = 55'({$urandom, $urandom});
            end
            if (!lp && $urandom_range(0, 2) != 0) begin
                lp = 1; loc_data = 55'({$urandom, $urandom});
            end
            fwd_valid = (fp != 0);
            loc_valid = (lp != 0);
            tx_ready  = ($urandom_range(0, 3) != 0);
            settle;
            e_fr = !m_busy && fp != 0 && (lp == 0 || m_streak < MAX);
            e_lr = !m_busy && lp != 0 && !e_fr;
            chk("rnd_fwd_ready", fwd_ready, e_fr);
            chk("rnd_loc_ready", loc_ready, e_lr);
            chk("rnd_tx_valid", tx_valid, m_busy);
            chk("rnd_tx_data", tx_data, m_frame);
            chk("rnd_src", grant_src, m_src);
            chk("rnd_fwd_cnt", fwd_count, m_fc % 65536);
            chk("rnd_loc_cnt", loc_count, m_lc % 65536);
            chk("rnd_fwd_cnt_w", s_fwd_count, m_fc % 16);
            chk("rnd_loc_cnt_w", s_loc_count, m_lc % 16);
            if (m_busy) begin
                if (tx_ready) begin
                    if (m_src) m_lc++; else m_fc++;
                    m_busy = 0;
                end
            end else if (e_fr) begin
                m_busy = 1; m_frame = fwd_data; m_src = 0; fp = 0;
                m_streak = (lp != 0) ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
            end else if (e_lr) begin
                m_busy = 1; m_frame = loc_data; m_src = 1; lp = 0;
                m_streak = 0;
            end
            tick;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
